// File: rtl/kernel_conv.sv
// ---------------------------------------------------------------------------
// kernel_conv
//   Programmable KxK convolution stage that sits directly behind the row-buffer
//   kernel generator. It produces one filtered pixel per pixel beat and delays
//   dv/dtype/meta so they stay aligned with the filtered pixel.
//
//   Stream semantics: there is no ready. A beat is present whenever dvi=1, and
//   it is accepted unconditionally on that clk edge. Exactly 3 clocks later
//   the matching dvo/dtypeo/meta_datao (and, for pixel beats, datao) appear.
//
//   Ports
//     clk, reset    pixel clock, asynchronous active-high reset
//     dvi, dtypei   data valid / data type from the kernel stage
//     kernel_datai  KxK window, element (r,c) at [(r*K+c)*PIXEL_WIDTH +: PIXEL_WIDTH]
//     meta_datai    header/meta word, passed through unmodified
//     enable        0 = pass the centre pixel through unfiltered
//     coeffs        KxK signed coefficients, same packing as kernel_datai
//     shift         normalisation right shift applied after the accumulate
//     dvo, dtypeo, meta_datao   inputs delayed by 3 clocks
//     datao         filtered pixel, updated only on pixel beats
//
//   Build option
//     KERNEL_CONV_ABS_EN : output the magnitude of the shifted sum instead of
//                          clamping negative results to 0.
// ---------------------------------------------------------------------------
module kernel_conv #(
    parameter int KERNEL_SIZE = 3,
    parameter int PIXEL_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int SHIFT_WIDTH = 4,
    parameter int DTYPE_WIDTH = 8,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = DTYPE_WIDTH'(8'h01),
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = DTYPE_WIDTH'(8'h40)
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        dvi,
    input  logic [DTYPE_WIDTH-1:0]                      dtypei,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] kernel_datai,
    input  logic [DATA_WIDTH-1:0]                       meta_datai,
    input  logic                                        enable,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*COEFF_WIDTH-1:0] coeffs,
    input  logic [SHIFT_WIDTH-1:0]                      shift,
    output logic                                        dvo,
    output logic [DTYPE_WIDTH-1:0]                      dtypeo,
    output logic [DATA_WIDTH-1:0]                       meta_datao,
    output logic [PIXEL_WIDTH-1:0]                      datao
);

    localparam int K      = KERNEL_SIZE;
    localparam int KK     = K * K;
    localparam int LOGK   = (K > 1) ? $clog2(K) : 1;
    localparam int PROD_W = PIXEL_WIDTH + COEFF_WIDTH + 1;
    localparam int ROW_W  = PROD_W + LOGK;
    localparam int TOT_W  = PROD_W + 2 * LOGK;
    localparam int CENTRE = (K / 2) * K + (K / 2);
    localparam logic signed [TOT_W-1:0] PIX_MAX = TOT_W'((1 << PIXEL_WIDTH) - 1);

    // Frame-level configuration, captured on FRAME_START beats.
    logic [KK*COEFF_WIDTH-1:0] cfg_coeffs;
    logic [SHIFT_WIDTH-1:0]    cfg_shift;
    logic                      cfg_enable;

    // Stage 1: products plus the config snapshot the beat entered with.
    logic                          s1_dv;
    logic [DTYPE_WIDTH-1:0]        s1_dtype;
    logic [DATA_WIDTH-1:0]         s1_meta;
    logic signed [PROD_W-1:0]      s1_prod [KK];
    logic [PIXEL_WIDTH-1:0]        s1_centre;
    logic [SHIFT_WIDTH-1:0]        s1_shift;
    logic                          s1_enable;

    // Stage 2: per-row partial sums.
    logic                          s2_dv;
    logic [DTYPE_WIDTH-1:0]        s2_dtype;
    logic [DATA_WIDTH-1:0]         s2_meta;
    logic signed [ROW_W-1:0]       s2_row [K];
    logic [PIXEL_WIDTH-1:0]        s2_centre;
    logic [SHIFT_WIDTH-1:0]        s2_shift;
    logic                          s2_enable;

    logic signed [PROD_W-1:0]      prod_c  [KK];
    logic signed [ROW_W-1:0]       row_c   [K];
    logic signed [TOT_W-1:0]       total_c;
    logic signed [TOT_W-1:0]       rnd_c;
    logic signed [TOT_W-1:0]       shifted_c;
    logic signed [TOT_W-1:0]       mag_c;
    logic [PIXEL_WIDTH-1:0]        clamp_c;
    logic [PIXEL_WIDTH-1:0]        filt_c;
    logic                          out_pix;

    // Pixels are zero-extended by one bit so the signed multiply treats them
    // as non-negative; operands are widened first so no product can overflow.
    always_comb begin
        for (int i = 0; i < KK; i++) begin
            prod_c[i] = PROD_W'($signed({1'b0, kernel_datai[i*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                      * PROD_W'($signed(cfg_coeffs[i*COEFF_WIDTH +: COEFF_WIDTH]));
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) begin
            row_c[r] = '0;
            for (int c = 0; c < K; c++) begin
                row_c[r] = row_c[r] + ROW_W'(s1_prod[r*K+c]);
            end
        end
    end

    always_comb begin
        total_c = '0;
        for (int r = 0; r < K; r++) begin
            total_c = total_c + TOT_W'(s2_row[r]);
        end
        // Round half up before the arithmetic shift; no rounding when shift=0.
        rnd_c     = (s2_shift != '0) ? (TOT_W'(1) <<< (s2_shift - SHIFT_WIDTH'(1))) : '0;
        shifted_c = (total_c + rnd_c) >>> s2_shift;
`ifdef KERNEL_CONV_ABS_EN
        mag_c = shifted_c[TOT_W-1] ? -shifted_c : shifted_c;
`else
        mag_c = shifted_c;
`endif
        if (mag_c[TOT_W-1])
            clamp_c = '0;
        else if (mag_c > PIX_MAX)
            clamp_c = '1;
        else
            clamp_c = mag_c[PIXEL_WIDTH-1:0];
        filt_c  = s2_enable ? clamp_c : s2_centre;
        out_pix = s2_dv && ((s2_dtype & DTYPE_PIXEL_MASK) != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_coeffs <= '0;
            cfg_shift  <= '0;
            cfg_enable <= 1'b0;
        end else if (dvi && dtypei == DTYPE_FRAME_START) begin
            cfg_coeffs <= coeffs;
            cfg_shift  <= shift;
            cfg_enable <= enable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dv     <= 1'b0;
            s1_dtype  <= '0;
            s1_meta   <= '0;
            s1_centre <= '0;
            s1_shift  <= '0;
            s1_enable <= 1'b0;
            for (int i = 0; i < KK; i++) s1_prod[i] <= '0;
            s2_dv     <= 1'b0;
            s2_dtype  <= '0;
            s2_meta   <= '0;
            s2_centre <= '0;
            s2_shift  <= '0;
            s2_enable <= 1'b0;
            for (int r = 0; r < K; r++) s2_row[r] <= '0;
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            datao      <= '0;
        end else begin
            s1_dv     <= dvi;
            s1_dtype  <= dtypei;
            s1_meta   <= meta_datai;
            s1_centre <= kernel_datai[CENTRE*PIXEL_WIDTH +: PIXEL_WIDTH];
            s1_shift  <= cfg_shift;
            s1_enable <= cfg_enable;
            for (int i = 0; i < KK; i++) s1_prod[i] <= prod_c[i];
            s2_dv     <= s1_dv;
            s2_dtype  <= s1_dtype;
            s2_meta   <= s1_meta;
            s2_centre <= s1_centre;
            s2_shift  <= s1_shift;
            s2_enable <= s1_enable;
            for (int r = 0; r < K; r++) s2_row[r] <= row_c[r];
            dvo        <= s2_dv;
            dtypeo     <= s2_dtype;
            meta_datao <= s2_meta;
            if (out_pix) datao <= filt_c;
        end
    end

endmodule

// File: tb/tb_kernel_conv.sv
// ---------------------------------------------------------------------------
// tb_kernel_conv
//   Directed and randomised stimulus for kernel_conv. Every driven beat pushes
//   its expected {dvo, dtypeo, meta_datao, datao} record to exp_q; records are
//   popped and compared once they have had 3 clocks to emerge.
// ---------------------------------------------------------------------------
module tb_kernel_conv;

    localparam int K   = 3;
    localparam int KK  = K * K;
    localparam int PW  = 10;
    localparam int DW  = 16;
    localparam int CW  = 8;
    localparam int SW  = 4;
    localparam int TW  = 8;
    localparam int REC_W = 1 + TW + DW + PW;

    localparam logic [TW-1:0] DT_FS  = 8'h01;
    localparam logic [TW-1:0] DT_FE  = 8'h02;
    localparam logic [TW-1:0] DT_RS  = 8'h04;
    localparam logic [TW-1:0] DT_RE  = 8'h08;
    localparam logic [TW-1:0] DT_HDR = 8'h10;
    localparam logic [TW-1:0] DT_PIX = 8'h40;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 dvi = 1'b0;
    logic [TW-1:0]        dtypei = '0;
    logic [KK*PW-1:0]     kernel_datai = '0;
    logic [DW-1:0]        meta_datai = '0;
    logic                 enable = 1'b0;
    logic [KK*CW-1:0]     coeffs = '0;
    logic [SW-1:0]        shift = '0;
    logic                 dvo;
    logic [TW-1:0]        dtypeo;
    logic [DW-1:0]        meta_datao;
    logic [PW-1:0]        datao;

    always #5 clk = ~clk;

    kernel_conv #(
        .KERNEL_SIZE(K), .PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .COEFF_WIDTH(CW),
        .SHIFT_WIDTH(SW), .DTYPE_WIDTH(TW),
        .DTYPE_FRAME_START(DT_FS), .DTYPE_PIXEL_MASK(DT_PIX)
    ) dut (
        .clk(clk), .reset(reset), .dvi(dvi), .dtypei(dtypei),
        .kernel_datai(kernel_datai), .meta_datai(meta_datai),
        .enable(enable), .coeffs(coeffs), .shift(shift),
        .dvo(dvo), .dtypeo(dtypeo), .meta_datao(meta_datao), .datao(datao)
    );

    // Scoreboard and reference model state.
    logic [REC_W-1:0] exp_q[$];
    int               tests = 0;
    int               fails = 0;
    logic [KK*CW-1:0] m_coeffs = '0;
    logic [SW-1:0]    m_shift = '0;
    logic             m_enable = 1'b0;
    logic [PW-1:0]    m_hold = '0;

    function automatic logic [PW-1:0] model_pix(input logic [KK*PW-1:0] win,
                                                input logic [KK*CW-1:0] cf,
                                                input logic [SW-1:0] sh,
                                                input logic en);
        int sum;
        logic [CW-1:0] c8;
        if (!en) return win[4*PW +: PW];
        sum = 0;
        for (int i = 0; i < KK; i++) begin
            c8  = cf[i*CW +: CW];
            sum = sum + int'(win[i*PW +: PW]) * int'($signed(c8));
        end
        if (sh != 0) sum = sum + (1 << (sh - 1));
        sum = sum >>> sh;
`ifdef KERNEL_CONV_ABS_EN
        if (sum < 0) sum = -sum;
`endif
        if (sum < 0) return '0;
        if (sum > 1023) return 10'd1023;
        return PW'(sum);
    endfunction

    function automatic logic [KK*PW-1:0] flat(input int v);
        logic [KK*PW-1:0] w;
        for (int i = 0; i < KK; i++) w[i*PW +: PW] = PW'(v);
        return w;
    endfunction

    function automatic logic [KK*PW-1:0] ramp(input int base);
        logic [KK*PW-1:0] w;
        for (int i = 0; i < KK; i++) w[i*PW +: PW] = PW'(base + i * 7);
        return w;
    endfunction

    function automatic logic [KK*PW-1:0] rand_win();
        logic [KK*PW-1:0] w;
        for (int i = 0; i < KK; i++) w[i*PW +: PW] = PW'($urandom_range(0, 1023));
        return w;
    endfunction

    function automatic logic [KK*CW-1:0] coeff_all(input int v);
        logic [KK*CW-1:0] c;
        for (int i = 0; i < KK; i++) c[i*CW +: CW] = CW'(v);
        return c;
    endfunction

    function automatic logic [KK*CW-1:0] coeff_lap();
        logic [KK*CW-1:0] c;
        c = '0;
        c[1*CW +: CW] = -8'sd1;
        c[3*CW +: CW] = -8'sd1;
        c[5*CW +: CW] = -8'sd1;
        c[7*CW +: CW] = -8'sd1;
        c[4*CW +: CW] = 8'sd4;
        return c;
    endfunction

    task automatic check(input string tag, input logic [REC_W-1:0] obs,
                         input logic [REC_W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive, predict, then retire the beat driven 3 clocks ago.
    task automatic step(input logic dv, input logic [TW-1:0] dt,
                        input logic [KK*PW-1:0] win, input logic [DW-1:0] meta,
                        input string tag);
        @(negedge clk);
        dvi = dv; dtypei = dt; kernel_datai = win; meta_datai = meta;
        if (dv && (dt & DT_PIX) != 0)
            m_hold = model_pix(win, m_coeffs, m_shift, m_enable);
        exp_q.push_back({dv, dt, meta, m_hold});
        if (dv && dt == DT_FS) begin
            m_coeffs = coeffs; m_shift = shift; m_enable = enable;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) check(tag, {dvo, dtypeo, meta_datao, datao}, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, "idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; dvi = 1'b0; dtypei = '0; meta_datai = '0;
        #1;
        check("reset_async", {dvo, dtypeo, meta_datao, datao}, '0);
        @(posedge clk);
        #1;
        check("reset_hold", {dvo, dtypeo, meta_datao, datao}, '0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_coeffs = '0; m_shift = '0; m_enable = 1'b0; m_hold = '0;
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", {dvo, dtypeo, meta_datao, datao}, '0);
        @(negedge clk);
        reset = 1'b0;

        // Before any FRAME_START the latched enable is 0: centre passthrough.
        coeffs = coeff_all(1); shift = 4'd3; enable = 1'b1;
        step(1'b1, DT_HDR, '0, 16'hbeef, "pre_hdr");
        for (int i = 0; i < 3; i++) step(1'b1, DT_PIX, ramp(100 + i), 16'(i), "pre_pass");

        // Identity kernel on a ramp, with row markers.
        coeffs = '0; coeffs[4*CW +: CW] = 8'sd1; shift = '0; enable = 1'b1;
        step(1'b1, DT_FS, '0, 16'h1000, "id_fs");
        step(1'b1, DT_RS, '0, 16'h1001, "id_rs");
        for (int i = 0; i < 4; i++) step(1'b1, DT_PIX, ramp(200 + 13 * i), 16'(i), "identity");
        step(1'b0, DT_PIX, ramp(999), 16'h0, "dv0_hold");
        // Mid-frame change to all-zero coefficients is not yet visible.
        coeffs = '0;
        for (int i = 0; i < 3; i++) step(1'b1, DT_PIX, ramp(300 + i), 16'(i), "cfg_hold");
        step(1'b1, DT_RE, '0, 16'h1002, "id_re");
        step(1'b1, DT_FE, '0, 16'h1003, "id_fe");
        step(1'b1, DT_FS, '0, 16'h2000, "zero_fs");
        for (int i = 0; i < 3; i++) step(1'b1, DT_PIX, ramp(400 + i), 16'(i), "zero_out");

        // Box blur with rounding, then the saturating case.
        coeffs = coeff_all(1); shift = 4'd3; enable = 1'b1;
        step(1'b1, DT_FS, '0, 16'h3000, "box_fs");
        step(1'b1, DT_PIX, flat(80), 16'h3001, "box_80");
        step(1'b1, DT_PIX, flat(1023), 16'h3002, "box_1023");
        step(1'b1, DT_PIX, flat(0), 16'h3003, "box_0");

        // In-flight pixel keeps old coefficients when a FRAME_START follows it.
        coeffs = coeff_lap(); shift = '0;
        step(1'b1, DT_PIX, flat(80), 16'h3004, "inflight_old");
        step(1'b1, DT_FS, '0, 16'h4000, "lap_fs");
        begin
            logic [KK*PW-1:0] w;
            w = flat(50);
            w[1*PW +: PW] = 10'd200; w[3*PW +: PW] = 10'd200;
            w[5*PW +: PW] = 10'd200; w[7*PW +: PW] = 10'd200;
            w[4*PW +: PW] = 10'd0;
            step(1'b1, DT_PIX, w, 16'h4001, "laplace_neg");
            w[4*PW +: PW] = 10'd300;
            step(1'b1, DT_PIX, w, 16'h4002, "laplace_pos");
        end
        for (int i = 0; i < 4; i++) step(1'b1, DT_PIX, rand_win(), 16'($urandom), "laplace_rand");

        // Back-to-back FRAME_STARTs: the second one wins.
        coeffs = '0; coeffs[4*CW +: CW] = 8'sd1; shift = '0;
        step(1'b1, DT_FS, '0, 16'h5000, "b2b_fs1");
        coeffs = coeff_all(1); shift = 4'd3;
        step(1'b1, DT_FS, '0, 16'h5001, "b2b_fs2");
        step(1'b1, DT_PIX, flat(80), 16'h5002, "b2b_pix");

        // Explicit passthrough: enable=0 at FRAME_START.
        enable = 1'b0;
        step(1'b1, DT_FS, '0, 16'h6000, "pass_fs");
        for (int i = 0; i < 3; i++) step(1'b1, DT_PIX, rand_win(), 16'($urandom), "passthrough");
        step(1'b1, DT_HDR, rand_win(), 16'h6abc, "pass_hdr");

        // Random coefficients and shift.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < KK; i++) coeffs[i*CW +: CW] = CW'($urandom_range(0, 255));
            shift = SW'($urandom_range(0, 15)); enable = 1'b1;
            step(1'b1, DT_FS, '0, 16'($urandom), "rand_fs");
            for (int i = 0; i < 5; i++) step(1'b1, DT_PIX, rand_win(), 16'($urandom), "rand_pix");
        end

        // Reset mid-row, then resume; latched config is cleared (passthrough).
        for (int i = 0; i < 2; i++) step(1'b1, DT_PIX, rand_win(), 16'($urandom), "pre_rst");
        do_reset();
        idle(2);
        for (int i = 0; i < 3; i++) step(1'b1, DT_PIX, ramp(500 + i), 16'(i), "post_rst");
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
